// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with iterative shift-add multiply and restoring divide
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       selALU,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a, b, quick;
    logic [2*WIDTH-1:0] acc, mul_nxt, div_nxt;
    logic [WIDTH:0]     mul_sum, trial, diff;
    logic               last, div0;

    assign busy = state != IDLE;
    assign done = state == DONE;
    assign last = cnt == CNT_W'(WIDTH - 1);
    assign div0 = selALU == OP_DIV && op2 == '0;

    // accumulator upper half gains the multiplicand when the current multiplier bit is set, then shifts right
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b[0] ? {1'b0, a} : '0);
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // partial remainder shifts in the next dividend bit; a clear borrow means the subtraction is kept
    assign trial   = acc[2*WIDTH-1:WIDTH-1];
    assign diff    = trial - {1'b0, b};
    assign div_nxt = {diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]};

    // results of every operation that completes at the accepting edge
    always_comb begin
        quick = '0;
        case (selALU)
            4'b0000: quick = op1 + op2;
            4'b0001: quick = op1 - op2;
            4'b0011: quick = '1;
            4'b0110: quick = ~op1;
            4'b1010: quick = {WIDTH{op1 == op2}};
            4'b1011: quick = {WIDTH{op1 != op2}};
            4'b1100: quick = {WIDTH{op1 > op2}};
            4'b1101: quick = {WIDTH{op1 < op2}};
            default: quick = '0;
        endcase
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode; DONE always lasts a single cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = selALU == OP_MUL ? MUL : (selALU == OP_DIV && op2 != '0) ? DIV : DONE;
            MUL, DIV: if (last) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // operand capture, iteration datapath and output registers written only on entry to DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a           <= '0;
            b           <= '0;
            acc         <= '0;
            cnt         <= '0;
            result      <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a   <= op1;
                    b   <= op2;
                    cnt <= '0;
                    acc <= selALU == OP_DIV ? {{WIDTH{1'b0}}, op1} : '0;
                    if (state_nxt == DONE) begin
                        result      <= quick;
                        result_hi   <= div0 ? op1 : '0;
                        div_by_zero <= div0;
                    end
                end
                MUL: begin
                    acc <= mul_nxt;
                    b   <= b >> 1;
                    cnt <= last ? cnt : cnt + CNT_W'(1);
                    if (last) begin
                        result      <= mul_nxt[WIDTH-1:0];
                        result_hi   <= mul_nxt[2*WIDTH-1:WIDTH];
                        div_by_zero <= 1'b0;
                    end
                end
                DIV: begin
                    acc <= div_nxt;
                    cnt <= last ? cnt : cnt + CNT_W'(1);
                    if (last) begin
                        result      <= div_nxt[WIDTH-1:0];
                        result_hi   <= div_nxt[2*WIDTH-1:WIDTH];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8
module tb_seq_alu;
    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic        clock, reset;
    logic        start, start8;
    logic [31:0] op1, op2, result, result_hi;
    logic [7:0]  op1_8, op2_8, result8, result_hi8;
    logic [3:0]  selALU, sel8;
    logic        busy, done, div_by_zero;
    logic        busy8, done8, div_by_zero8;

    exp_t        q32[$], q8[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] h_res = 0, h_hi = 0, h8_res = 0, h8_hi = 0;
    logic        h_dbz = 0, h8_dbz = 0;
    logic [3:0]  codes [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'hA, 4'hB, 4'hC, 4'hD, 4'h4};

    seq_alu #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op1(op1), .op2(op2), .selALU(selALU),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op1(op1_8), .op2(op2_8), .selALU(sel8),
        .busy(busy8), .done(done8), .result(result8), .result_hi(result_hi8), .div_by_zero(div_by_zero8)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // reference: plain arithmetic on the opcode meaning; cyc carries the latency
    function automatic exp_t model(input int w, input logic [3:0] sel, input logic [63:0] x, input logic [63:0] y);
        exp_t        e;
        logic [63:0] m, p;
        m = (64'd1 << w) - 1;
        e.res = 0;
        e.hi  = 0;
        e.dbz = 0;
        e.cyc = 1;
        case (sel)
            4'h0: e.res = (x + y) & m;
            4'h1: e.res = (x - y) & m;
            4'h2: begin
                p = x * y;
                e.res = p & m;
                e.hi  = (p >> w) & m;
                e.cyc = w + 1;
            end
            4'h3: if (y == 0) begin
                e.res = m;
                e.hi  = x;
                e.dbz = 1;
            end else begin
                e.res = x / y;
                e.hi  = x % y;
                e.cyc = w + 1;
            end
            4'h6: e.res = ~x & m;
            4'hA: e.res = x == y ? m : 0;
            4'hB: e.res = x != y ? m : 0;
            4'hC: e.res = x > y ? m : 0;
            4'hD: e.res = x < y ? m : 0;
            default: e.res = 0;
        endcase
        return e;
    endfunction

    // called #1 after a rising edge; returns #1 after the accepting edge
    task automatic issue(input int which, input logic [3:0] sel, input logic [63:0] x, input logic [63:0] y);
        int   n = 0;
        exp_t e;
        while ((which != 0 ? busy8 : busy) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout unit %0d still busy want idle", which);
        end
        e = model(which != 0 ? 8 : 32, sel, x, y);
        e.cyc = cyc + e.cyc;
        if (which != 0) begin
            start8 = 1;
            sel8   = sel;
            op1_8  = x[7:0];
            op2_8  = y[7:0];
            q8.push_back(e);
        end else begin
            start  = 1;
            selALU = sel;
            op1    = x[31:0];
            op2    = y[31:0];
            q32.push_back(e);
        end
        @(posedge clock);
        #1;
        start  = 0;
        start8 = 0;
        op1    = $urandom;
        op2    = $urandom;
        op1_8  = 8'($urandom);
        op2_8  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending %0d/%0d want 0/0", q32.size(), q8.size());
            q32.delete();
            q8.delete();
        end
    endtask

    // 32-bit monitor: compare at each done, otherwise outputs must hold the last completed values
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            h_res = 0;
            h_hi  = 0;
            h_dbz = 0;
        end else if (done) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done32 got done at cycle %0d want none", cyc);
            end else begin
                e = q32.pop_front();
                chk("latency32", 64'(cyc), 64'(e.cyc));
                chk("result32", 64'(result), e.res);
                chk("result_hi32", 64'(result_hi), e.hi);
                chk("dbz32", 64'(div_by_zero), 64'(e.dbz));
                h_res = e.res;
                h_hi  = e.hi;
                h_dbz = e.dbz;
            end
        end else begin
            chk("hold_result32", 64'(result), h_res);
            chk("hold_hi32", 64'(result_hi), h_hi);
            chk("hold_dbz32", 64'(div_by_zero), 64'(h_dbz));
        end
    end

    // 8-bit monitor
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            h8_res = 0;
            h8_hi  = 0;
            h8_dbz = 0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done8 got done at cycle %0d want none", cyc);
            end else begin
                e = q8.pop_front();
                chk("latency8", 64'(cyc), 64'(e.cyc));
                chk("result8", 64'(result8), e.res);
                chk("result_hi8", 64'(result_hi8), e.hi);
                chk("dbz8", 64'(div_by_zero8), 64'(e.dbz));
                h8_res = e.res;
                h8_hi  = e.hi;
                h8_dbz = e.dbz;
            end
        end else begin
            chk("hold_result8", 64'(result8), h8_res);
            chk("hold_hi8", 64'(result_hi8), h8_hi);
            chk("hold_dbz8", 64'(div_by_zero8), 64'(h8_dbz));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset  = 1;
        start  = 0;
        start8 = 0;
        op1    = 0;
        op2    = 0;
        selALU = 0;
        op1_8  = 0;
        op2_8  = 0;
        sel8   = 0;
        @(posedge clock);
        #1;
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);
        chk("reset_result", 64'(result), 0);
        chk("reset_hi", 64'(result_hi), 0);
        chk("reset_dbz", 64'(div_by_zero), 0);
        reset = 0;

        issue(0, 4'h0, 64'hFFFF_FFFF, 64'd2);
        chk("sum_busy_in_done", 64'(busy), 1);
        @(posedge clock);
        #1;
        chk("sum_busy_after", 64'(busy), 0);
        issue(0, 4'h1, 64'd3, 64'd5);
        issue(0, 4'h2, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        issue(0, 4'h2, 64'h1_0000, 64'h1_0000);
        issue(0, 4'h3, 64'd100, 64'd7);
        issue(0, 4'h3, 64'h1234_5678, 64'd0);
        issue(0, 4'h0, 64'd9, 64'd1);
        issue(0, 4'hA, 64'd5, 64'd5);
        issue(0, 4'hC, 64'd1, 64'h8000_0000);
        issue(0, 4'h6, 64'h0F0F_0F0F, 64'd0);
        issue(0, 4'h7, 64'd123, 64'd456);
        wait_idle();

        // start held high with changing inputs through a multiply: exactly one extra acceptance, after done
        e = model(32, 4'h2, 64'hDEAD_BEEF, 64'h1234_5678);
        e.cyc = cyc + e.cyc;
        q32.push_back(e);
        start  = 1;
        selALU = 4'h2;
        op1    = 32'hDEAD_BEEF;
        op2    = 32'h1234_5678;
        @(posedge clock);
        #1;
        selALU = 4'h0;
        op1    = 32'h0000_1111;
        op2    = 32'h0000_2222;
        e = model(32, 4'h0, 64'h1111, 64'h2222);
        e.cyc = cyc + 34;
        q32.push_back(e);
        repeat (34) @(posedge clock);
        #1;
        start = 0;
        wait_idle();

        // asynchronous reset in the middle of a multiply
        issue(0, 4'h2, 64'h8765_4321, 64'h0BAD_F00D);
        repeat (10) @(posedge clock);
        #2;
        reset = 1;
        #1;
        chk("midreset_busy", 64'(busy), 0);
        chk("midreset_done", 64'(done), 0);
        chk("midreset_result", 64'(result), 0);
        chk("midreset_hi", 64'(result_hi), 0);
        chk("midreset_dbz", 64'(div_by_zero), 0);
        q32.delete();
        @(posedge clock);
        #1;
        reset = 0;
        issue(0, 4'h3, 64'd1000, 64'd33);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  s;
            logic [63:0] x, y;
            int          md;
            s = codes[$urandom_range(0, 9)];
            if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(0, 15));
            x  = 64'($urandom);
            md = $urandom_range(0, 3);
            y  = md == 0 ? 64'd0 : md == 1 ? x : 64'($urandom);
            issue(0, s, x, y);
        end
        wait_idle();

        issue(1, 4'h2, 64'hFF, 64'hFF);
        issue(1, 4'h3, 64'hFF, 64'h10);
        for (int i = 0; i < 20; i++) begin
            logic [3:0]  s;
            logic [63:0] x, y;
            s = codes[$urandom_range(0, 9)];
            x = 64'($urandom_range(0, 255));
            y = $urandom_range(0, 3) == 0 ? 64'd0 : 64'($urandom_range(0, 255));
            issue(1, s, x, y);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
